mips_top: RTL and testbench

Top level of a single-cycle 32-bit MIPS-subset processor with a unified word-addressed program/data memory. It is the highest module of the CPU design: it takes only a clock and a reset, and exposes 16 LED outputs. Programs are loaded into memory by backdoor during reset. A program signals completion by storing 1 to word 320; its result is stored to word 321.

---
 rtl/mips_top.sv | 172 +++++++++++++++++
 tb/tb_mips_top.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mips_top.sv
// Single-cycle 32-bit MIPS-subset CPU with a unified word-addressed program/data memory.
// The LED register mirrors the low half of every store to the result word.

module mips_ram #(
  parameter int unsigned MEM_WORDS = 512,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] i_idx_i,
  input  logic [AW-1:0] d_idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   instr_o,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [0:MEM_WORDS-1];

  assign instr_o = mem[i_idx_i];
  assign rdata_o = mem[d_idx_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[d_idx_i] <= wdata_i;
  end
endmodule

module mips_mem #(
  parameter int unsigned MEM_WORDS = 512,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] i_idx_i,
  input  logic [AW-1:0] d_idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   instr_o,
  output logic [31:0]   rdata_o
);
  mips_ram #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk_i  (clk_i),
    .we_i   (we_i),
    .i_idx_i(i_idx_i),
    .d_idx_i(d_idx_i),
    .wdata_i(wdata_i),
    .instr_o(instr_o),
    .rdata_o(rdata_o)
  );
endmodule

module mips_top #(
  parameter int unsigned MEM_WORDS = 512,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_arst,
  output logic [15:0] o_leds
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] LedWord = AW'(321);

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  logic [31:0] pc_q, pc_d, pc_plus4, br_target, instr;
  logic [31:0] rd1, rd2, alu_b, alu_y, mem_rdata, wb_data, imm_sext, imm_zext;
  logic [31:0] rf_q [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic [15:0] imm;
  logic        reg_write, reg_dst, use_imm, zext_imm, mem_write, mem_to_reg;
  logic        br_eq, br_ne, jump, taken, mem_we;
  logic        unused_shamt;
  alu_op_e     alu_op;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0, imm};
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    use_imm    = 1'b0;
    zext_imm   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    jump       = 1'b0;
    alu_op     = AluAdd;
    unique case (op)
      6'h00: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        unique case (funct)
          6'h20:   alu_op = AluAdd;
          6'h22:   alu_op = AluSub;
          6'h24:   alu_op = AluAnd;
          6'h25:   alu_op = AluOr;
          6'h2A:   alu_op = AluSlt;
          default: reg_write = 1'b0;
        endcase
      end
      6'h08: begin reg_write = 1'b1; use_imm = 1'b1; end
      6'h0C: begin reg_write = 1'b1; use_imm = 1'b1; zext_imm = 1'b1; alu_op = AluAnd; end
      6'h0D: begin reg_write = 1'b1; use_imm = 1'b1; zext_imm = 1'b1; alu_op = AluOr; end
      6'h23: begin reg_write = 1'b1; use_imm = 1'b1; mem_to_reg = 1'b1; end
      6'h2B: begin use_imm = 1'b1; mem_write = 1'b1; end
      6'h04: br_eq = 1'b1;
      6'h05: br_ne = 1'b1;
      6'h02: jump = 1'b1;
      default: ;
    endcase
  end

  assign rd1   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rd2   = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign alu_b = use_imm ? (zext_imm ? imm_zext : imm_sext) : rd2;

  always_comb begin
    alu_y = 32'h0;
    unique case (alu_op)
      AluAdd:  alu_y = rd1 + alu_b;
      AluSub:  alu_y = rd1 - alu_b;
      AluAnd:  alu_y = rd1 & alu_b;
      AluOr:   alu_y = rd1 | alu_b;
      AluSlt:  alu_y = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = 32'h0;
    endcase
  end

  assign wa      = reg_dst ? rd : rt;
  assign wb_data = mem_to_reg ? mem_rdata : alu_y;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign taken     = (br_eq && (rd1 == rd2)) || (br_ne && (rd1 != rd2));

  always_comb begin
    pc_d = pc_plus4;
    if (jump)       pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken) pc_d = br_target;
  end

  // Memory is not reset, so stores are blocked while reset holds to protect backdoor loads.
  assign mem_we = mem_write && !i_arst;

  mips_mem #(.MEM_WORDS(MEM_WORDS)) mem (
    .clk_i  (i_clk),
    .we_i   (mem_we),
    .i_idx_i(pc_q[AW+1:2]),
    .d_idx_i(alu_y[AW+1:2]),
    .wdata_i(rd2),
    .instr_o(instr),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      pc_q   <= RESET_PC;
      o_leds <= 16'h0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (reg_write && (wa != 5'd0)) rf_q[wa] <= wb_data;
      if (mem_write && (alu_y[AW+1:2] == LedWord)) o_leds <= rd2[15:0];
    end
  end
endmodule

// File: tb/tb_mips_top.sv
// Directed bench for mips_top: hand-assembled programs loaded by backdoor during reset,
// results checked in memory, registers and the LED port.

module tb_mips_top;
  localparam int unsigned MemWords = 512;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b1;
  logic [15:0] o_leds;
  int          n_checks = 0;
  int          n_errors = 0;

  mips_top #(.MEM_WORDS(MemWords), .RESET_PC(32'h0)) dut (
    .i_clk (i_clk),
    .i_arst(i_arst),
    .o_leds(o_leds)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < MemWords; i++) dut.mem.u_mem.mem[i] = 32'h0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.mem.u_mem.mem[idx] = w;
  endtask

  // Sum 1..6, store 21 to word 321 then flag to word 320.
  task automatic load_sum();
    clear_mem();
    put(0, i_op(8'h08, 0, 1, 6));
    put(1, i_op(8'h08, 0, 2, 0));
    put(2, r_op(2, 1, 2, 8'h20));
    put(3, i_op(8'h08, 1, 1, -1));
    put(4, i_op(8'h05, 1, 0, -3));
    put(5, i_op(8'h2B, 0, 2, 32'h504));
    put(6, i_op(8'h08, 0, 3, 1));
    put(7, i_op(8'h2B, 0, 3, 32'h500));
    put(8, j_op(8));
  endtask

  task automatic load_misc();
    clear_mem();
    put(0,  i_op(8'h08, 0, 1, 7));
    put(1,  i_op(8'h08, 0, 2, -3));
    put(2,  r_op(1, 2, 3, 8'h20));
    put(3,  i_op(8'h2B, 0, 3, 1320));
    put(4,  r_op(1, 2, 3, 8'h22));
    put(5,  i_op(8'h2B, 0, 3, 1324));
    put(6,  r_op(1, 2, 3, 8'h24));
    put(7,  i_op(8'h2B, 0, 3, 1328));
    put(8,  r_op(1, 2, 3, 8'h25));
    put(9,  i_op(8'h2B, 0, 3, 1332));
    put(10, r_op(2, 1, 3, 8'h2A));
    put(11, i_op(8'h2B, 0, 3, 1336));
    put(12, r_op(1, 2, 3, 8'h2A));
    put(13, i_op(8'h2B, 0, 3, 1340));
    // Build 0xDEADBEEF: ori 0xDEAD, double 16 times, ori 0xBEEF.
    put(14, i_op(8'h0D, 0, 4, 32'hDEAD));
    put(15, i_op(8'h08, 0, 6, 16));
    put(16, r_op(4, 4, 4, 8'h20));
    put(17, i_op(8'h08, 6, 6, -1));
    put(18, i_op(8'h05, 6, 0, -3));
    put(19, i_op(8'h0D, 4, 4, 32'hBEEF));
    put(20, i_op(8'h2B, 0, 4, 1600));
    put(21, i_op(8'h23, 0, 5, 1600));
    put(22, i_op(8'h2B, 0, 5, 1604));
    put(23, i_op(8'h08, 0, 0, 5));
    put(24, i_op(8'h2B, 0, 0, 1608));
    put(25, i_op(8'h08, 0, 7, 0));
    put(26, i_op(8'h04, 1, 1, 1));
    put(27, i_op(8'h08, 7, 7, 100));
    put(28, i_op(8'h08, 7, 7, 1));
    put(29, i_op(8'h04, 1, 2, 1));
    put(30, i_op(8'h08, 7, 7, 1));
    put(31, j_op(34));
    put(32, i_op(8'h08, 7, 7, 10));
    put(33, i_op(8'h2B, 0, 1, 1616));
    put(34, i_op(8'h2B, 0, 7, 1612));
    put(35, i_op(8'h08, 0, 3, 1));
    put(36, i_op(8'h2B, 0, 3, 1280));
    put(37, j_op(37));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (dut.mem.u_mem.mem[320] !== 32'd1 && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, " done"}, {31'd0, dut.mem.u_mem.mem[320] === 32'd1}, 32'd1);
  endtask

  initial begin
    // Sum program from power-on reset
    i_arst = 1'b1;
    load_sum();
    repeat (2) @(negedge i_clk);
    check("rst pc", dut.pc_q, 32'h0);
    check("rst leds", {16'h0, o_leds}, 32'h0);
    check("rst r1", dut.rf_q[1], 32'h0);
    i_arst = 1'b0;
    wait_done("sum");
    check("sum result", dut.mem.u_mem.mem[321], 32'd21);
    check("sum leds", {16'h0, o_leds}, 32'h15);

    // Reset while parked after completion clears leds, pc and registers
    #2 i_arst = 1'b1;
    #1;
    check("rst2 pc", dut.pc_q, 32'h0);
    check("rst2 leds", {16'h0, o_leds}, 32'h0);
    check("rst2 r2", dut.rf_q[2], 32'h0);

    // Reset in the middle of the loop
    load_sum();
    @(negedge i_clk) i_arst = 1'b0;
    repeat (10) @(negedge i_clk);
    check("mid r2", dut.rf_q[2], 32'd15);
    check("mid r1", dut.rf_q[1], 32'd3);
    #2 i_arst = 1'b1;
    #1;
    check("mid rst pc", dut.pc_q, 32'h0);
    check("mid rst r1", dut.rf_q[1], 32'h0);
    check("mid rst r2", dut.rf_q[2], 32'h0);
    check("mid rst leds", {16'h0, o_leds}, 32'h0);
    check("mid no flag", dut.mem.u_mem.mem[320], 32'h0);
    load_sum();
    @(negedge i_clk);
    @(negedge i_clk) i_arst = 1'b0;
    wait_done("rerun");
    check("rerun result", dut.mem.u_mem.mem[321], 32'd21);
    check("rerun leds", {16'h0, o_leds}, 32'h15);

    // ALU, memory, zero register and control flow
    @(negedge i_clk) i_arst = 1'b1;
    load_misc();
    @(negedge i_clk) i_arst = 1'b0;
    wait_done("misc");
    check("add", dut.mem.u_mem.mem[330], 32'd4);
    check("sub", dut.mem.u_mem.mem[331], 32'd10);
    check("and", dut.mem.u_mem.mem[332], 32'd5);
    check("or", dut.mem.u_mem.mem[333], 32'hFFFF_FFFF);
    check("slt", dut.mem.u_mem.mem[334], 32'd1);
    check("slt rev", dut.mem.u_mem.mem[335], 32'd0);
    check("sw word 400", dut.mem.u_mem.mem[400], 32'hDEAD_BEEF);
    check("lw copy 401", dut.mem.u_mem.mem[401], 32'hDEAD_BEEF);
    check("zero reg", dut.mem.u_mem.mem[402], 32'h0);
    check("branch count", dut.mem.u_mem.mem[403], 32'd2);
    check("jump skipped sw", dut.mem.u_mem.mem[404], 32'h0);
    check("misc leds", {16'h0, o_leds}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
